// File: rtl/spi_enc_pkg.sv
// Shared types, legal parameter limits and the stuck-frame check for the
// SPI absolute-encoder master.
package spi_enc_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} spi_state_e;

  localparam int FRAME_BITS_MIN = 2;
  localparam int FRAME_BITS_MAX = 32;
  localparam int CLK_DIV_MIN    = 4;
  localparam int CS_SETUP_MIN   = 1;
  localparam int CS_GAP_MIN     = 1;

  // A frame whose low nbits are all 0 or all 1 means a dead or shorted line.
  function automatic logic frame_is_stuck(input logic [FRAME_BITS_MAX-1:0] frame,
                                          input int unsigned nbits);
    logic [FRAME_BITS_MAX-1:0] mask;
    mask = (nbits >= FRAME_BITS_MAX) ? '1
         : ((FRAME_BITS_MAX'(1) << nbits) - FRAME_BITS_MAX'(1));
    return ((frame & mask) == '0) || ((frame & mask) == mask);
  endfunction

endpackage

// File: rtl/spi_encoder_master_if.sv
// Host-side and pin-side signals of the encoder master, bundled.
interface spi_encoder_master_if #(
  parameter int FRAME_BITS = 24,
  parameter int DATA_W     = 19
);
  logic                  enable;
  logic                  continuous;
  logic                  miso;
  logic                  sck;
  logic                  cs_n;
  logic [FRAME_BITS-1:0] frame_raw;
  logic [DATA_W-1:0]     pos_val;
  logic                  data_valid;
  logic                  err_stuck;
  logic                  busy;

  modport master (
    input  enable, continuous, miso,
    output sck, cs_n, frame_raw, pos_val, data_valid, err_stuck, busy
  );

  modport slave (
    output enable, continuous, miso,
    input  sck, cs_n, frame_raw, pos_val, data_valid, err_stuck, busy
  );
endinterface

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period tick counter with leading/trailing strobes.
// lead_o marks the end of a full bit period; sck only swings to the active
// level there when hold_i is low (i.e. another bit follows).
module spi_sck_gen
  import spi_enc_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter bit CPOL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  input  logic hold_i,
  output logic sck_o,
  output logic lead_o,
  output logic trail_o
);
  localparam int HW = $clog2(CLK_DIV);

  if (CLK_DIV < CLK_DIV_MIN) begin : g_bad_clk_div
    $error("spi_sck_gen: CLK_DIV below minimum");
  end

  logic [HW-1:0] half_cnt_q;
  logic          phase_q;
  logic          sck_q;
  logic          tick;

  assign tick    = run_i && (half_cnt_q == HW'(CLK_DIV - 1));
  assign lead_o  = tick && phase_q;
  assign trail_o = tick && !phase_q;
  assign sck_o   = sck_q;

  // Count half periods and toggle sck; idle at CPOL whenever not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
      sck_q      <= CPOL;
    end else if (start_i) begin
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
      sck_q      <= ~CPOL;
    end else if (run_i) begin
      if (tick) begin
        half_cnt_q <= '0;
        phase_q    <= ~phase_q;
        if (!phase_q) begin
          sck_q <= CPOL;
        end else if (!hold_i) begin
          sck_q <= ~CPOL;
        end
      end else begin
        half_cnt_q <= half_cnt_q + 1'b1;
      end
    end else begin
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
      sck_q      <= CPOL;
    end
  end
endmodule

// File: rtl/spi_encoder_master.sv
// SPI master polling an absolute encoder: frames CS_n/SCK, shifts in an
// MSB-first frame, extracts the position field and flags stuck lines.
module spi_encoder_master
  import spi_enc_pkg::*;
#(
  parameter int FRAME_BITS = 24,
  parameter int DATA_MSB   = 21,
  parameter int DATA_LSB   = 3,
  parameter int CLK_DIV    = 50,
  parameter int CS_SETUP   = 25,
  parameter int CS_GAP     = 100,
  parameter bit CPOL       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_encoder_master_if.master bus
);
  localparam int DATA_W  = DATA_MSB - DATA_LSB + 1;
  localparam int CNT_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);

  if (FRAME_BITS < FRAME_BITS_MIN || FRAME_BITS > FRAME_BITS_MAX) begin : g_bad_frame_bits
    $error("spi_encoder_master: FRAME_BITS out of range");
  end
  if (DATA_MSB >= FRAME_BITS) begin : g_bad_data_msb
    $error("spi_encoder_master: DATA_MSB must be below FRAME_BITS");
  end
  if (DATA_LSB < 0 || DATA_LSB > DATA_MSB) begin : g_bad_data_lsb
    $error("spi_encoder_master: DATA_LSB out of range");
  end
  if (CS_SETUP < CS_SETUP_MIN) begin : g_bad_cs_setup
    $error("spi_encoder_master: CS_SETUP below minimum");
  end
  if (CS_GAP < CS_GAP_MIN) begin : g_bad_cs_gap
    $error("spi_encoder_master: CS_GAP below minimum");
  end

  spi_state_e            state_q;
  logic                  cs_n_q;
  logic                  busy_q;
  logic                  data_valid_q;
  logic                  err_stuck_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [FRAME_BITS-1:0] frame_raw_q;
  logic [DATA_W-1:0]     pos_val_q;
  logic [1:0]            miso_sync_q;

  logic sck;
  logic sck_lead;
  logic sck_trail;
  logic sck_start;
  logic sck_run;
  logic sck_hold;
  logic frame_stuck;

  assign sck_start   = (state_q == SETUP) && (cnt_q == CNT_W'(CS_SETUP - 1));
  assign sck_run     = (state_q == SHIFT);
  assign sck_hold    = (bit_cnt_q == BIT_W'(FRAME_BITS));
  assign frame_stuck = frame_is_stuck(FRAME_BITS_MAX'(shreg_q), FRAME_BITS);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sck_gen (
    .clk     (clk),
    .rst     (rst),
    .start_i (sck_start),
    .run_i   (sck_run),
    .hold_i  (sck_hold),
    .sck_o   (sck),
    .lead_o  (sck_lead),
    .trail_o (sck_trail)
  );

  // Two-flop synchroniser for the asynchronous encoder data line.
  always_ff @(posedge clk) begin
    if (rst) miso_sync_q <= '0;
    else     miso_sync_q <= {miso_sync_q[0], bus.miso};
  end

  // Frame sequencer with registered chip select, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
      err_stuck_q  <= 1'b0;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      frame_raw_q  <= '0;
      pos_val_q    <= '0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.enable || bus.continuous) begin
            state_q   <= SETUP;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
          end
        end
        SETUP: begin
          if (sck_start) state_q <= SHIFT;
          else           cnt_q   <= cnt_q + 1'b1;
        end
        SHIFT: begin
          if (sck_trail) begin
            shreg_q   <= {shreg_q[FRAME_BITS-2:0], miso_sync_q[1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          // The bit period after the last trailing edge is the CS hold time.
          if (sck_lead && sck_hold) begin
            state_q <= DONE;
            cs_n_q  <= 1'b1;
          end
        end
        DONE: begin
          frame_raw_q  <= shreg_q;
          data_valid_q <= 1'b1;
          err_stuck_q  <= frame_stuck;
          if (!frame_stuck) pos_val_q <= shreg_q[DATA_MSB:DATA_LSB];
          state_q      <= GAP;
          cnt_q        <= '0;
        end
        GAP: begin
          if (cnt_q == CNT_W'(CS_GAP - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sck        = sck;
  assign bus.cs_n       = cs_n_q;
  assign bus.frame_raw  = frame_raw_q;
  assign bus.pos_val    = pos_val_q;
  assign bus.data_valid = data_valid_q;
  assign bus.err_stuck  = err_stuck_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_spi_encoder_master.sv
// Scoreboard bench for spi_encoder_master: an encoder model serves queued
// words, the stimulus pushes the expected results, monitors compare.
module tb_spi_encoder_master;
  localparam int FB       = 24;
  localparam int DLSB     = 3;
  localparam int DW       = 19;
  localparam int CLK_DIV  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_encoder_master_if #(.FRAME_BITS(FB), .DATA_W(DW)) bus();

  spi_encoder_master #(
    .FRAME_BITS (FB),
    .DATA_MSB   (21),
    .DATA_LSB   (DLSB),
    .CLK_DIV    (CLK_DIV),
    .CS_SETUP   (2),
    .CS_GAP     (3),
    .CPOL       (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [FB-1:0] raw;
    logic [DW-1:0] pos;
    logic          stuck;
  } exp_t;

  exp_t          exp_q[$];
  logic [FB-1:0] enc_q[$];
  logic [DW-1:0] model_pos = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: a frame's position is its bit-field, kept only for good frames.
  task automatic push_frame(input logic [FB-1:0] w);
    exp_t e;
    logic stuck;
    stuck = (w == '0) || (w == '1);
    if (!stuck) model_pos = DW'(w >> DLSB);
    e.raw   = w;
    e.pos   = model_pos;
    e.stuck = stuck;
    exp_q.push_back(e);
    enc_q.push_back(w);
  endtask

  // Encoder model: new word per CS assertion, next bit on each SCK leading (falling) edge.
  logic [FB-1:0] enc_word = '0;
  int            enc_idx  = 0;
  always @(negedge bus.cs_n) begin
    if (enc_q.size() > 0) enc_word = enc_q.pop_front();
    enc_idx = FB - 1;
  end
  always @(negedge bus.sck) begin
    if (!bus.cs_n && enc_idx >= 0) begin
      bus.miso = enc_word[enc_idx];
      enc_idx--;
    end
  end

  // Result monitor: pop and compare on every data_valid; track output stability.
  int            dv_count = 0;
  int            unstable = 0;
  exp_t          mon_e;
  logic [FB-1:0] prev_raw = '0;
  logic [DW-1:0] prev_pos = '0;
  logic          prev_err = 1'b0;
  always @(negedge clk) begin
    if (bus.data_valid) begin
      dv_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_data_valid: got frame 0x%0h at cycle %0d, required no pulse", bus.frame_raw, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_raw", 32'(bus.frame_raw), 32'(mon_e.raw));
        check("pos_val", 32'(bus.pos_val), 32'(mon_e.pos));
        check("err_stuck", 32'(bus.err_stuck), 32'(mon_e.stuck));
      end
    end else if (!bus.cs_n && (bus.frame_raw != prev_raw || bus.pos_val != prev_pos || bus.err_stuck != prev_err)) begin
      unstable++;
    end
    prev_raw = bus.frame_raw;
    prev_pos = bus.pos_val;
    prev_err = bus.err_stuck;
  end

  // Waveform monitor: SCK timing inside each CS window, CS high time between frames.
  logic        sck_prev = 1'b1;
  logic        csn_prev = 1'b1;
  logic        first_seen = 1'b0;
  logic        aborted = 1'b0;
  int          falls = 0;
  int          bad_half = 0;
  int          idle_edges = 0;
  int          hi_len = 0;
  int          csn_hi_len_last = 0;
  int unsigned first_delay = 0;
  int unsigned cs_fall_cyc = 0;
  int unsigned last_edge_cyc = 0;
  always @(negedge clk) begin
    if (rst && !bus.cs_n) aborted = 1'b1;
    if (csn_prev && !bus.cs_n) begin
      csn_hi_len_last = hi_len;
      falls       = 0;
      bad_half    = 0;
      first_seen  = 1'b0;
      first_delay = 0;
      aborted     = rst;
      cs_fall_cyc = cyc;
    end
    if (bus.cs_n) hi_len++;
    else          hi_len = 0;
    if (bus.sck != sck_prev) begin
      if (bus.cs_n && csn_prev) begin
        idle_edges++;
      end else if (!bus.cs_n) begin
        if (!first_seen) begin
          first_seen  = 1'b1;
          first_delay = cyc - cs_fall_cyc;
        end else if (cyc - last_edge_cyc != CLK_DIV) begin
          bad_half++;
        end
        if (!bus.sck) falls++;
        last_edge_cyc = cyc;
      end
    end
    if (!csn_prev && bus.cs_n && !aborted) begin
      if (cyc - last_edge_cyc != CLK_DIV) bad_half++;
      check("sck_falls_per_frame", 32'(falls), 32'd24);
      check("sck_half_period_errors", 32'(bad_half), 32'd0);
      check("first_fall_after_cs", first_delay, 32'd2);
    end
    sck_prev = bus.sck;
    csn_prev = bus.cs_n;
  end

  // Drive enable for one cycle; t0 is the cycle count just after the sampling edge.
  task automatic pulse_enable(output int unsigned t0);
    bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_dv(input int limit, output int unsigned t);
    logic found;
    found = 1'b0;
    t = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(posedge clk); #1;
      if (bus.data_valid) begin
        found = 1'b1;
        t = cyc;
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL data_valid_timeout: got none in %0d cycles, required a pulse", limit);
    end
  endtask

  task automatic wait_idle(input int limit);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < limit && !idle; i++) begin
      if (!bus.busy) idle = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!idle) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy after %0d cycles, required idle", limit);
    end
  endtask

  task automatic single_shot(input logic [FB-1:0] w);
    int unsigned t0, t1;
    push_frame(w);
    pulse_enable(t0);
    wait_dv(400, t1);
    check("frame_latency", t1 - t0, 32'd195);
    wait_idle(50);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, 32'(bus.cs_n), 32'd1);
    check({tag, "_sck"}, 32'(bus.sck), 32'd1);
    check({tag, "_frame_raw"}, 32'(bus.frame_raw), 32'd0);
    check({tag, "_pos_val"}, 32'(bus.pos_val), 32'd0);
    check({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
    check({tag, "_err_stuck"}, 32'(bus.err_stuck), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int unsigned t0, t1, t2, t3;
    int          dv0;
    logic [FB-1:0] w;

    bus.enable     = 1'b0;
    bus.continuous = 1'b0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Stuck-high frame keeps pos_val at 0; a good frame then updates it.
    single_shot(24'hFFFFFF);
    single_shot(24'h000008);

    // Single shot with a known pattern and the exact latency.
    single_shot(24'h5AC3F1);

    // Continuous polling: period, CS high time, clean stop after dropping continuous.
    for (int i = 0; i < 3; i++) push_frame(FB'($urandom));
    dv0 = dv_count;
    bus.continuous = 1'b1;
    wait_dv(400, t1);
    wait_dv(400, t2);
    check("continuous_period", t2 - t1, 32'd199);
    check("cs_high_between_frames", 32'(csn_hi_len_last), 32'd5);
    repeat (60) @(posedge clk);
    #1;
    bus.continuous = 1'b0;
    wait_dv(400, t3);
    check("last_continuous_period", t3 - t2, 32'd199);
    repeat (20) @(posedge clk);
    #1;
    check("busy_after_continuous", 32'(bus.busy), 32'd0);
    check("continuous_frame_count", 32'(dv_count - dv0), 32'd3);

    // A second enable while busy is neither honoured nor queued.
    push_frame(FB'($urandom));
    dv0 = dv_count;
    pulse_enable(t0);
    repeat (49) @(posedge clk);
    #1;
    bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    wait_dv(400, t1);
    check("busy_enable_latency", t1 - t0, 32'd195);
    repeat (300) @(posedge clk);
    #1;
    check("busy_enable_frame_count", 32'(dv_count - dv0), 32'd1);
    check("busy_after_single", 32'(bus.busy), 32'd0);

    // Reset mid-frame: outputs clear at once and the partial frame is dropped.
    enc_q.push_back(FB'($urandom));
    pulse_enable(t0);
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midframe_reset");
    rst       = 1'b0;
    model_pos = '0;
    dv0       = dv_count;
    repeat (250) @(posedge clk);
    #1;
    check("no_dv_after_reset", 32'(dv_count - dv0), 32'd0);
    single_shot(FB'($urandom));

    // Randomised single shots, including occasional stuck frames.
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 7))
        0:       w = '0;
        1:       w = '1;
        default: w = FB'($urandom);
      endcase
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      single_shot(w);
    end

    wait_idle(50);
    check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
    check("sck_edges_while_cs_high", 32'(idle_edges), 32'd0);
    check("outputs_changed_mid_frame", 32'(unstable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
